// File: rtl/arb_client_if.sv
// Local-job and arbiter-lane signals of one requester agent.
// master: the agent itself. slave: the job source and arbiter side.
interface arb_client_if #(
  parameter int LEN_W = 4
);
  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic             req;
  logic             grant;
  logic             beat_valid;
  logic             beat_last;
  logic [LEN_W-1:0] beat_idx;
  logic             done;
  logic             timeout_err;
  logic             busy;

  modport master (
    input  job_valid, job_len, grant,
    output job_ready, req, beat_valid, beat_last, beat_idx, done, timeout_err, busy
  );

  modport slave (
    output job_valid, job_len, grant,
    input  job_ready, req, beat_valid, beat_last, beat_idx, done, timeout_err, busy
  );
endinterface

// File: rtl/arb_client.sv
// Requester agent for one arbiter lane: takes a job, requests the lane, issues
// len beats while granted (stalling on preemption), then releases the lane for one cycle.
module arb_client #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  arb_client_if.master bus
);
  localparam int WAIT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int WAIT_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  state_t            r_state;
  logic [LEN_W-1:0]  r_len;
  logic [WAIT_W-1:0] r_wait;
  logic              r_job_ready;
  logic              r_req;
  logic              r_beat_valid;
  logic              r_beat_last;
  logic [LEN_W-1:0]  r_beat_idx;
  logic              r_done;
  logic              r_timeout_err;
  logic              r_busy;

  logic [LEN_W-1:0]  w_next_idx;
  logic [LEN_W-1:0]  w_last_idx;

  // While stalled, r_beat_idx holds the last issued beat, so the next beat is always +1.
  assign w_next_idx = r_beat_idx + LEN_W'(1);
  assign w_last_idx = r_len - LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_wait        <= '0;
      r_job_ready   <= 1'b1;
      r_req         <= 1'b0;
      r_beat_valid  <= 1'b0;
      r_beat_last   <= 1'b0;
      r_beat_idx    <= '0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.job_valid && r_job_ready) begin
            r_state     <= REQ;
            r_len       <= (bus.job_len == '0) ? LEN_W'(1) : bus.job_len;
            r_wait      <= '0;
            r_req       <= 1'b1;
            r_job_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        REQ: begin
          // Grant takes priority over an expiry in the same cycle.
          if (bus.grant) begin
            r_state      <= XFER;
            r_beat_valid <= 1'b1;
            r_beat_idx   <= '0;
            r_beat_last  <= (w_last_idx == '0);
          end else if ((TIMEOUT > 0) && (r_wait == WAIT_W'(WAIT_LIM))) begin
            r_state       <= RELEASE;
            r_req         <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        XFER: begin
          if (r_beat_valid && r_beat_last) begin
            r_state      <= RELEASE;
            r_req        <= 1'b0;
            r_done       <= 1'b1;
            r_beat_valid <= 1'b0;
            r_beat_last  <= 1'b0;
            r_beat_idx   <= '0;
          end else if (bus.grant) begin
            r_beat_valid <= 1'b1;
            r_beat_idx   <= w_next_idx;
            r_beat_last  <= (w_next_idx == w_last_idx);
          end else begin
            r_beat_valid <= 1'b0;
            r_beat_last  <= 1'b0;
          end
        end
        RELEASE: begin
          r_state     <= IDLE;
          r_job_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_req       <= 1'b0;
          r_job_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.job_ready   = r_job_ready;
  assign bus.req         = r_req;
  assign bus.beat_valid  = r_beat_valid;
  assign bus.beat_last   = r_beat_last;
  assign bus.beat_idx    = r_beat_idx;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_timeout_err;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_arb_client.sv
// Directed bench for arb_client: each scenario walks a per-cycle table of expected
// outputs {req, job_ready, busy, beat_valid, beat_last, beat_idx, done, timeout_err}.
module tb_arb_client;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  arb_client_if #(.LEN_W(4)) bus ();

  arb_client #(.LEN_W(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // beat_idx only carries meaning alongside beat_valid
  logic [10:0] obs;
  assign obs = {bus.req, bus.job_ready, bus.busy, bus.beat_valid, bus.beat_last,
                (bus.beat_valid ? bus.beat_idx : 4'd0), bus.done, bus.timeout_err};

  function automatic logic [10:0] mk(int r, int rd, int b, int bv, int bl, int idx, int d, int t);
    return {r[0], rd[0], b[0], bv[0], bl[0], idx[3:0], d[0], t[0]};
  endfunction

  task automatic test_reset();
    bus.job_valid = 1'b0;
    bus.job_len   = 4'd0;
    bus.grant     = 1'b0;
    #1 rst = 1'b1;
    #1;
    if (obs !== mk(1 - 1, 1, 0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_state got %b expected %b", obs, mk(0, 1, 0, 0, 0, 0, 0, 0));
    end
    checks++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if (obs !== mk(0, 1, 0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_release got %b expected %b", obs, mk(0, 1, 0, 0, 0, 0, 0, 0));
    end
    checks++;
  endtask

  task automatic test_basic();
    logic [10:0] e [6];
    e = '{mk(1,0,1,0,0,0,0,0), mk(1,0,1,1,0,0,0,0), mk(1,0,1,1,0,1,0,0),
          mk(1,0,1,1,1,2,0,0), mk(0,0,1,0,0,0,1,0), mk(0,1,0,0,0,0,0,0)};
    bus.job_valid = 1'b1; bus.job_len = 4'd3; bus.grant = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL basic cycle %0d got %b expected %b", k + 1, obs, e[k]);
      end
      checks++;
      bus.job_valid = 1'b0;
      bus.grant     = (k < 4);
    end
  endtask

  task automatic test_len0();
    logic [10:0] e [4];
    e = '{mk(1,0,1,0,0,0,0,0), mk(1,0,1,1,1,0,0,0), mk(0,0,1,0,0,0,1,0), mk(0,1,0,0,0,0,0,0)};
    bus.job_valid = 1'b1; bus.job_len = 4'd0; bus.grant = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL len0 cycle %0d got %b expected %b", k + 1, obs, e[k]);
      end
      checks++;
      bus.job_valid = 1'b0;
      bus.grant     = (k < 2);
    end
  endtask

  task automatic test_timeout();
    logic [10:0] exp_v;
    bus.job_valid = 1'b1; bus.job_len = 4'd2; bus.grant = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      exp_v = (k < 16) ? mk(1,0,1,0,0,0,0,0) :
              (k == 16) ? mk(0,0,1,0,0,0,0,1) : mk(0,1,0,0,0,0,0,0);
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL timeout cycle %0d got %b expected %b", k + 1, obs, exp_v);
      end
      checks++;
      bus.job_valid = 1'b0;
    end
  endtask

  task automatic test_preempt();
    logic [10:0] e [11];
    e = '{mk(1,0,1,0,0,0,0,0), mk(1,0,1,1,0,0,0,0), mk(1,0,1,1,0,1,0,0),
          mk(1,0,1,0,0,0,0,0), mk(1,0,1,0,0,0,0,0), mk(1,0,1,0,0,0,0,0),
          mk(1,0,1,1,0,2,0,0), mk(1,0,1,1,0,3,0,0), mk(1,0,1,1,1,4,0,0),
          mk(0,0,1,0,0,0,1,0), mk(0,1,0,0,0,0,0,0)};
    bus.job_valid = 1'b1; bus.job_len = 4'd5; bus.grant = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL preempt cycle %0d got %b expected %b", k + 1, obs, e[k]);
      end
      checks++;
      bus.job_valid = 1'b0;
      bus.grant     = (k < 2) || (k >= 5 && k < 9);
    end
  endtask

  task automatic test_grant_at_expiry();
    logic [10:0] exp_v;
    bus.job_valid = 1'b1; bus.job_len = 4'd1; bus.grant = 1'b0;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      exp_v = (k < 16) ? mk(1,0,1,0,0,0,0,0) :
              (k == 16) ? mk(1,0,1,1,1,0,0,0) :
              (k == 17) ? mk(0,0,1,0,0,0,1,0) : mk(0,1,0,0,0,0,0,0);
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL expiry_grant cycle %0d got %b expected %b", k + 1, obs, exp_v);
      end
      checks++;
      bus.job_valid = 1'b0;
      bus.grant     = (k == 15);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e [8];
    e = '{mk(1,0,1,0,0,0,0,0), mk(1,0,1,1,1,0,0,0), mk(0,0,1,0,0,0,1,0), mk(0,1,0,0,0,0,0,0),
          mk(1,0,1,0,0,0,0,0), mk(1,0,1,1,1,0,0,0), mk(0,0,1,0,0,0,1,0), mk(0,1,0,0,0,0,0,0)};
    bus.job_valid = 1'b1; bus.job_len = 4'd1; bus.grant = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %b expected %b", k + 1, obs, e[k]);
      end
      checks++;
      if (k == 4) bus.job_valid = 1'b0;
    end
    bus.grant = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    bus.job_valid = 1'b1; bus.job_len = 4'd5; bus.grant = 1'b0;
    @(negedge clk);
    bus.job_valid = 1'b0;
    bus.grant     = 1'b1;
    repeat (2) @(negedge clk);
    if (obs !== mk(1,0,1,1,0,1,0,0)) begin
      errors++;
      $display("FAIL mid_xfer_setup got %b expected %b", obs, mk(1,0,1,1,0,1,0,0));
    end
    checks++;
    #2 rst = 1'b1;
    #1;
    if (obs !== mk(0,1,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL mid_xfer_reset got %b expected %b", obs, mk(0,1,0,0,0,0,0,0));
    end
    checks++;
    @(negedge clk);
    rst       = 1'b0;
    bus.grant = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (obs !== mk(0,1,0,0,0,0,0,0)) begin
        errors++;
        $display("FAIL mid_xfer_after got %b expected %b", obs, mk(0,1,0,0,0,0,0,0));
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_timeout();
    test_preempt();
    test_grant_at_expiry();
    test_back_to_back();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
